// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM state type and the
// default source count.
package intr_pkg;

    localparam int NUM_SRC_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_e;

endpackage : intr_pkg

// File: rtl/intr_prio_enc.sv
// Combinational priority encoder: the lowest set index wins.
module prio_enc #(
    parameter int N    = 8,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) id_o = ID_W'(i);
        end
    end

endmodule : prio_enc

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detected pending bits, enable mask, and a
// request/claim/complete handshake with the CPU.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               mask_we_i,
    input  logic [NUM_SRC-1:0] mask_wdata_i,
    input  logic               intr_taken_i,
    input  logic               mret_i,
    output logic               e_intr_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] mask_o,
    output logic               busy_o
);

    intr_state_e        state_q;
    logic               e_intr_q;
    logic               busy_q;
    logic [ID_W-1:0]    irq_id_q;

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic               arm_q;   // low for the first cycle after reset release

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] active;
    logic               claim;
    logic               enc_vld;
    logic [ID_W-1:0]    enc_id;

    // Edge detect is suppressed until src_q has sampled real levels once, so
    // sources already high at reset release do not look like fresh edges.
    assign rise      = arm_q ? (src_i & ~src_q) : '0;
    assign claim     = (state_q == REQ) && intr_taken_i;
    assign clr       = claim ? (NUM_SRC'(1) << irq_id_q) : '0;
    // A new edge on the claimed source beats the clear.
    assign pending_d = (pending_q & ~clr) | rise;
    assign active    = pending_q & mask_q;

    prio_enc #(
        .N    (NUM_SRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req_i   (active),
        .valid_o (enc_vld),
        .id_o    (enc_id)
    );

    // Source sampling, pending bits and the enable mask.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            arm_q     <= 1'b0;
        end else begin
            src_q     <= src_i;
            pending_q <= pending_d;
            arm_q     <= 1'b1;
            if (mask_we_i) mask_q <= mask_wdata_i;
        end
    end

    // Request FSM with registered outputs; the id is latched on entry to REQ
    // and held until the FSM is back in IDLE, where it reads as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            e_intr_q <= 1'b0;
            busy_q   <= 1'b0;
            irq_id_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_vld) begin
                        state_q  <= REQ;
                        e_intr_q <= 1'b1;
                        irq_id_q <= enc_id;
                    end
                end
                REQ: begin
                    if (intr_taken_i) begin
                        state_q  <= SERVICE;
                        e_intr_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end else if (!(pending_q[irq_id_q] && mask_q[irq_id_q])) begin
                        state_q  <= IDLE;
                        e_intr_q <= 1'b0;
                        irq_id_q <= '0;
                    end
                end
                SERVICE: begin
                    if (mret_i) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        irq_id_q <= '0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    e_intr_q <= 1'b0;
                    busy_q   <= 1'b0;
                    irq_id_q <= '0;
                end
            endcase
        end
    end

    assign e_intr_o  = e_intr_q;
    assign busy_o    = busy_q;
    assign irq_id_o  = irq_id_q;
    assign pending_o = pending_q;
    assign mask_o    = mask_q;

endmodule : intr_ctrl

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: per-scenario tasks with inline checks and
// a scoreboard of expected request ids popped whenever e_intr_o is raised.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [7:0] src_i;
    logic       mask_we_i;
    logic [7:0] mask_wdata_i;
    logic       intr_taken_i;
    logic       mret_i;
    logic       e_intr_o;
    logic [2:0] irq_id_o;
    logic [7:0] pending_o;
    logic [7:0] mask_o;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp;

    intr_ctrl #(.NUM_SRC(8), .ID_W(3)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .src_i        (src_i),
        .mask_we_i    (mask_we_i),
        .mask_wdata_i (mask_wdata_i),
        .intr_taken_i (intr_taken_i),
        .mret_i       (mret_i),
        .e_intr_o     (e_intr_o),
        .irq_id_o     (irq_id_o),
        .pending_o    (pending_o),
        .mask_o       (mask_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        src_i = '0; mask_we_i = 0; mask_wdata_i = '0; intr_taken_i = 0; mret_i = 0;
        rst_ni = 0;
        tick(); tick();
        rst_ni = 1;
        tick(); tick();
    endtask

    task automatic set_mask(input logic [7:0] m);
        mask_we_i = 1; mask_wdata_i = m;
        tick();
        mask_we_i = 0;
    endtask

    task automatic test_reset();
        src_i = '0; mask_we_i = 0; mask_wdata_i = '0; intr_taken_i = 0; mret_i = 0;
        rst_ni = 0;
        #3;
        checks++;
        if ({e_intr_o, irq_id_o, pending_o, mask_o, busy_o} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {e_intr_o, irq_id_o, pending_o, mask_o, busy_o});
        end
        tick();
        rst_ni = 1;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        set_mask(8'hFF);
        checks++;
        if (mask_o !== 8'hFF) begin failures++; $display("FAIL basic_mask got=%h exp=ff", mask_o); end
        src_i = 8'h08; exp_q.push_back(3'd3);
        tick();
        checks++;
        if ({pending_o, e_intr_o} !== {8'h08, 1'b0}) begin
            failures++; $display("FAIL basic_pending got=%h/%b exp=08/0", pending_o, e_intr_o);
        end
        tick();
        checks++;
        if (e_intr_o !== 1'b1) begin failures++; $display("FAIL basic_e_intr got=%b exp=1", e_intr_o); end
        exp = exp_q.pop_front(); checks++;
        if (irq_id_o !== exp) begin failures++; $display("FAIL basic_id got=%0d exp=%0d", irq_id_o, exp); end
        src_i = 8'h00; intr_taken_i = 1;
        tick();
        intr_taken_i = 0;
        checks++;
        if ({busy_o, e_intr_o, pending_o, irq_id_o} !== {1'b1, 1'b0, 8'h00, 3'd3}) begin
            failures++; $display("FAIL basic_claim got=%b/%b/%h/%0d exp=1/0/00/3", busy_o, e_intr_o, pending_o, irq_id_o);
        end
        mret_i = 1;
        tick();
        mret_i = 0;
        checks++;
        if ({busy_o, e_intr_o, irq_id_o} !== {1'b0, 1'b0, 3'd0}) begin
            failures++; $display("FAIL basic_mret got=%b/%b/%0d exp=0/0/0", busy_o, e_intr_o, irq_id_o);
        end
    endtask

    task automatic test_two_src();
        do_reset();
        set_mask(8'hFF);
        src_i = 8'h24; exp_q.push_back(3'd2); exp_q.push_back(3'd5);
        tick();
        tick();
        checks++;
        if (e_intr_o !== 1'b1) begin failures++; $display("FAIL two_e_intr got=%b exp=1", e_intr_o); end
        exp = exp_q.pop_front(); checks++;
        if (irq_id_o !== exp) begin failures++; $display("FAIL two_id_first got=%0d exp=%0d", irq_id_o, exp); end
        intr_taken_i = 1;
        tick();
        intr_taken_i = 0;
        checks++;
        if ({pending_o, busy_o} !== {8'h20, 1'b1}) begin
            failures++; $display("FAIL two_claim got=%h/%b exp=20/1", pending_o, busy_o);
        end
        mret_i = 1;
        tick();
        mret_i = 0;
        checks++;
        if ({e_intr_o, busy_o} !== 2'b00) begin failures++; $display("FAIL two_idle_gap got=%b/%b exp=0/0", e_intr_o, busy_o); end
        tick();
        checks++;
        if (e_intr_o !== 1'b1) begin failures++; $display("FAIL two_reraise got=%b exp=1", e_intr_o); end
        exp = exp_q.pop_front(); checks++;
        if (irq_id_o !== exp) begin failures++; $display("FAIL two_id_second got=%0d exp=%0d", irq_id_o, exp); end
    endtask

    task automatic test_mask_gate();
        do_reset();
        src_i = 8'h02;
        tick();
        checks++;
        if (pending_o !== 8'h02) begin failures++; $display("FAIL gate_pending got=%h exp=02", pending_o); end
        tick(); tick();
        checks++;
        if (e_intr_o !== 1'b0) begin failures++; $display("FAIL gate_masked got=%b exp=0", e_intr_o); end
        exp_q.push_back(3'd1);
        set_mask(8'h02);
        checks++;
        if ({mask_o, e_intr_o} !== {8'h02, 1'b0}) begin
            failures++; $display("FAIL gate_mask_wr got=%h/%b exp=02/0", mask_o, e_intr_o);
        end
        tick();
        checks++;
        if (e_intr_o !== 1'b1) begin failures++; $display("FAIL gate_e_intr got=%b exp=1", e_intr_o); end
        exp = exp_q.pop_front(); checks++;
        if (irq_id_o !== exp) begin failures++; $display("FAIL gate_id got=%0d exp=%0d", irq_id_o, exp); end
    endtask

    task automatic test_mask_drop();
        do_reset();
        set_mask(8'hFF);
        src_i = 8'h10; exp_q.push_back(3'd4);
        tick(); tick();
        exp = exp_q.pop_front(); checks++;
        if ({e_intr_o, irq_id_o} !== {1'b1, exp}) begin
            failures++; $display("FAIL drop_req got=%b/%0d exp=1/%0d", e_intr_o, irq_id_o, exp);
        end
        set_mask(8'hEF);
        tick();
        checks++;
        if ({e_intr_o, busy_o, pending_o[4], irq_id_o} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
            failures++; $display("FAIL drop_idle got=%b/%b/%b/%0d exp=0/0/1/0", e_intr_o, busy_o, pending_o[4], irq_id_o);
        end
    endtask

    task automatic test_no_rearb();
        do_reset();
        set_mask(8'hFF);
        src_i = 8'h10; exp_q.push_back(3'd4);
        tick(); tick();
        exp = exp_q.pop_front(); checks++;
        if ({e_intr_o, irq_id_o} !== {1'b1, exp}) begin
            failures++; $display("FAIL rearb_first got=%b/%0d exp=1/%0d", e_intr_o, irq_id_o, exp);
        end
        src_i = 8'h12; exp_q.push_back(3'd1);
        tick(); tick();
        checks++;
        if ({e_intr_o, irq_id_o, pending_o} !== {1'b1, 3'd4, 8'h12}) begin
            failures++; $display("FAIL rearb_hold got=%b/%0d/%h exp=1/4/12", e_intr_o, irq_id_o, pending_o);
        end
        intr_taken_i = 1;
        tick();
        intr_taken_i = 0; mret_i = 1;
        tick();
        mret_i = 0;
        tick();
        exp = exp_q.pop_front(); checks++;
        if ({e_intr_o, irq_id_o} !== {1'b1, exp}) begin
            failures++; $display("FAIL rearb_next got=%b/%0d exp=1/%0d", e_intr_o, irq_id_o, exp);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        set_mask(8'hFF);
        src_i = 8'h40; exp_q.push_back(3'd6);
        tick();
        src_i = 8'h00;
        tick();
        exp = exp_q.pop_front(); checks++;
        if ({e_intr_o, irq_id_o} !== {1'b1, exp}) begin
            failures++; $display("FAIL setwin_req got=%b/%0d exp=1/%0d", e_intr_o, irq_id_o, exp);
        end
        src_i = 8'h40; intr_taken_i = 1;
        tick();
        intr_taken_i = 0;
        checks++;
        if ({pending_o[6], busy_o, e_intr_o} !== 3'b110) begin
            failures++; $display("FAIL setwin_claim got=%b/%b/%b exp=1/1/0", pending_o[6], busy_o, e_intr_o);
        end
        exp_q.push_back(3'd6);
        mret_i = 1;
        tick();
        mret_i = 0;
        tick();
        exp = exp_q.pop_front(); checks++;
        if ({e_intr_o, irq_id_o} !== {1'b1, exp}) begin
            failures++; $display("FAIL setwin_again got=%b/%0d exp=1/%0d", e_intr_o, irq_id_o, exp);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        set_mask(8'hFF);
        intr_taken_i = 1; mret_i = 1;
        tick();
        intr_taken_i = 0; mret_i = 0;
        checks++;
        if ({busy_o, e_intr_o} !== 2'b00) begin failures++; $display("FAIL ign_idle got=%b/%b exp=0/0", busy_o, e_intr_o); end
        src_i = 8'h01; exp_q.push_back(3'd0);
        tick(); tick();
        exp = exp_q.pop_front(); checks++;
        if ({e_intr_o, irq_id_o} !== {1'b1, exp}) begin
            failures++; $display("FAIL ign_req got=%b/%0d exp=1/%0d", e_intr_o, irq_id_o, exp);
        end
        mret_i = 1;
        tick();
        mret_i = 0;
        checks++;
        if ({e_intr_o, busy_o} !== 2'b10) begin failures++; $display("FAIL ign_mret_req got=%b/%b exp=1/0", e_intr_o, busy_o); end
        intr_taken_i = 1; mret_i = 1;
        tick();
        mret_i = 0;
        checks++;
        if ({e_intr_o, busy_o} !== 2'b01) begin failures++; $display("FAIL ign_both got=%b/%b exp=0/1", e_intr_o, busy_o); end
        tick();
        intr_taken_i = 0;
        set_mask(8'h00);
        checks++;
        if ({busy_o, mask_o, irq_id_o} !== {1'b1, 8'h00, 3'd0}) begin
            failures++; $display("FAIL ign_service got=%b/%h/%0d exp=1/00/0", busy_o, mask_o, irq_id_o);
        end
        mret_i = 1;
        tick();
        mret_i = 0;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL ign_done got=%b exp=0", busy_o); end
    endtask

    task automatic test_reset_async();
        do_reset();
        set_mask(8'hFF);
        src_i = 8'hFF; exp_q.push_back(3'd0);
        tick();
        checks++;
        if (pending_o !== 8'hFF) begin failures++; $display("FAIL arst_pending got=%h exp=ff", pending_o); end
        tick();
        exp = exp_q.pop_front(); checks++;
        if ({e_intr_o, irq_id_o} !== {1'b1, exp}) begin
            failures++; $display("FAIL arst_req got=%b/%0d exp=1/%0d", e_intr_o, irq_id_o, exp);
        end
        intr_taken_i = 1;
        tick();
        intr_taken_i = 0;
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL arst_service got=%b exp=1", busy_o); end
        #2;
        rst_ni = 0;
        #1;
        checks++;
        if ({e_intr_o, irq_id_o, pending_o, mask_o, busy_o} !== 20'h0) begin
            failures++;
            $display("FAIL arst_async got=%h exp=0", {e_intr_o, irq_id_o, pending_o, mask_o, busy_o});
        end
        tick();
        rst_ni = 1;
        tick(); tick(); tick();
        checks++;
        if ({pending_o, e_intr_o, busy_o} !== 10'h0) begin
            failures++; $display("FAIL arst_release got=%h/%b/%b exp=00/0/0", pending_o, e_intr_o, busy_o);
        end
        src_i = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_src();
        test_mask_gate();
        test_mask_drop();
        test_no_rearb();
        test_set_wins();
        test_ignored();
        test_reset_async();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_intr_ctrl

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, meaning number of interrupt sources (2..32).
REQ-002 SHALL have parameter ID_W, default $clog2(NUM_SRC), meaning width of the source id.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port src_i  input  NUM_SRC  interrupt source levels, synchronous to clk_i.
REQ-006 SHALL have port mask_we_i  input  1  write strobe for the enable mask.
REQ-007 SHALL have port mask_wdata_i  input  NUM_SRC  new enable mask value (1 = enabled).
REQ-008 SHALL have port intr_taken_i  input  1  one-cycle pulse: CPU has taken the interrupt (claim).
REQ-009 SHALL have port mret_i  input  1  one-cycle pulse: CPU executed MRET (complete).
REQ-010 SHALL have port e_intr_o  output  1  interrupt request to the CPU decode stage.
REQ-011 SHALL have port irq_id_o  output  ID_W  id of the requested or in-service source.
REQ-012 SHALL have port pending_o  output  NUM_SRC  pending bit per source.
REQ-013 SHALL have port mask_o  output  NUM_SRC  current enable mask.
REQ-014 SHALL have port busy_o  output  1  high while in SERVICE.

Function
REQ-015 SHALL register src_i once and set pending[i] on the cycle after a 0->1 edge of src_i[i], independent of mask.
REQ-016 SHALL implement FSM states IDLE, REQ, SERVICE.
REQ-017 IDLE: SHALL move to REQ when (pending & mask) != 0, latching irq_id = lowest set index of (pending & mask).
REQ-018 REQ: SHALL drive e_intr_o = 1 and hold irq_id_o stable; SHALL not re-arbitrate even if a lower index becomes pending.
REQ-019 REQ: on intr_taken_i SHALL clear pending[irq_id], move to SERVICE, deassert e_intr_o next cycle.
REQ-020 REQ: if pending[irq_id] & mask[irq_id] becomes 0 without intr_taken_i, SHALL return to IDLE and deassert e_intr_o next cycle.
REQ-021 SERVICE: SHALL keep e_intr_o = 0, busy_o = 1, irq_id_o held; on mret_i SHALL return to IDLE.
REQ-022 Latency: source edge at cycle N -> pending at N+1 -> e_intr_o at N+2 (IDLE, enabled, highest priority).
REQ-023 After mret_i at cycle M, a still-pending enabled source SHALL re-raise e_intr_o at M+2 (IDLE for one cycle).
REQ-024 Simultaneous new edge on src i and claim of i: set SHALL win; pending[i] stays 1.
REQ-025 intr_taken_i outside REQ and mret_i outside SERVICE SHALL be ignored.
REQ-026 intr_taken_i and mret_i together in REQ: claim SHALL be processed, mret ignored.
REQ-027 mask_we_i SHALL update mask the next cycle in any state; no effect on SERVICE.
REQ-028 irq_id_o SHALL be 0 in IDLE.

Reset
REQ-029 rst_ni low SHALL asynchronously force state IDLE, pending 0, mask 0, registered src 0, irq_id 0, e_intr_o 0, busy_o 0.
REQ-030 Reset mid-REQ or mid-SERVICE SHALL drop e_intr_o immediately; no edge SHALL be detected on the first cycle after release for sources already high.

Structure
REQ-031 Shared package intr_pkg SHALL hold the FSM state typedef (IDLE, REQ, SERVICE) and the NUM_SRC default constant.
REQ-032 One sub-module prio_enc (combinational lowest-index-first encoder, outputs valid + id) SHALL be used; everything else in intr_ctrl.

Verification
REQ-033 mask=0xFF, pulse src_i[3] -> pending_o=0x08 next cycle, e_intr_o=1 and irq_id_o=3 one cycle later.
REQ-034 src 5 and 2 edge together, mask=0xFF -> irq_id_o=2; intr_taken_i -> pending_o=0x20, busy_o=1; mret_i -> irq_id_o=5, e_intr_o=1 two cycles after mret_i.
REQ-035 mask=0x00, edge src 1 -> pending_o=0x02, e_intr_o stays 0; write mask=0x02 -> e_intr_o=1, irq_id_o=1 two cycles after mask_we_i.
REQ-036 In REQ for id 4, write mask=0xEF -> e_intr_o=0 next cycle, state IDLE, pending_o[4] still 1.
REQ-037 In REQ for id 6, new edge of src 6 coincident with intr_taken_i -> pending_o[6]=1, state SERVICE.
REQ-038 Assert rst_ni=0 during SERVICE with src_i=0xFF held -> all outputs 0 asynchronously; after release no pending bits set.
